// File: rtl/rib_ram_slave_pkg.sv
// Shared definitions for the RIB RAM slave: bus widths, write-enable
// polarity, FSM state encodings and the address offset helper.
package rib_ram_slave_pkg;

  localparam int MEM_BUS_W      = 32;
  localparam int MEM_ADDR_BUS_W = 32;

  // Polarity of we_i / latched write flag that means "write"
  localparam logic WRITE_ENABLE = 1'b1;

  // FSM encodings kept as plain constants for compatibility with older code
  localparam logic [1:0] RIB_IDLE = 2'd0;
  localparam logic [1:0] RIB_WAIT = 2'd1;
  localparam logic [1:0] RIB_RESP = 2'd2;

  // Byte offset of an address from the region base; wraps modulo 2^32 so
  // addresses below the base become huge offsets and decode as out of range.
  function automatic logic [MEM_ADDR_BUS_W-1:0] region_offset(
    input logic [MEM_ADDR_BUS_W-1:0] addr,
    input logic [MEM_ADDR_BUS_W-1:0] base
  );
    return addr - base;
  endfunction

endpackage

// File: rtl/rib_ram_slave_array.sv
// Single-port synchronous RAM, DEPTH x 32, with a registered read port.
// The read register clears on reset and can be forced to load zero so the
// controlling FSM can return 0 for out-of-range reads.
module rib_ram_array
  import rib_ram_slave_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic                 re,
  input  logic                 rzero,
  input  logic [IDX_W-1:0]     idx,
  input  logic [MEM_BUS_W-1:0] wdata,
  output logic [MEM_BUS_W-1:0] rdata
);

  logic [MEM_BUS_W-1:0] mem_r [DEPTH];

  // Storage write port; contents are deliberately never reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[idx] <= wdata;
    end
  end

  // Read register: cleared by reset, loaded only when a read is captured
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= {MEM_BUS_W{1'b0}};
    end else if (re) begin
      rdata <= rzero ? {MEM_BUS_W{1'b0}} : mem_r[idx];
    end
  end

endmodule

// File: rtl/rib_ram_slave.sv
// RIB slave RAM region with programmable wait states. Requests are accepted
// in IDLE (hold asserted combinationally in that same cycle), held for
// WAIT_CYCLES further cycles, then answered in a single RESP cycle.
module rib_ram_slave
  import rib_ram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [MEM_ADDR_BUS_W-1:0] addr_i,
  input  logic [MEM_BUS_W-1:0]      data_i,
  output logic [MEM_BUS_W-1:0]      data_o,
  output logic                      hold_flag_o,
  output logic                      err_o
);

  localparam int          IDX_W        = $clog2(DEPTH);
  localparam logic [31:0] REGION_BYTES = 32'(DEPTH * 4);
  localparam logic        HAS_WAIT     = (WAIT_CYCLES > 0);
  localparam logic [3:0]  WAIT_INIT    = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]                state_r;
  logic [1:0]                next_state_s;
  logic [3:0]                cnt_r;
  logic                      we_r;
  logic [IDX_W-1:0]          idx_r;
  logic                      in_range_r;
  logic                      err_r;

  logic [MEM_ADDR_BUS_W-1:0] offset_s;
  logic                      in_range_s;
  logic [IDX_W-1:0]          addr_idx_s;
  logic                      accept_s;
  logic                      hold_s;
  logic                      ram_we_s;
  logic                      ram_re_s;
  logic                      ram_rzero_s;
  logic [IDX_W-1:0]          ram_idx_s;
  logic [MEM_BUS_W-1:0]      ram_rdata_s;

  // Address decode of the live request address
  always_comb begin
    offset_s   = region_offset(addr_i, BASE_ADDR);
    in_range_s = (offset_s < REGION_BYTES);
    addr_idx_s = offset_s[IDX_W+1:2];
  end

  // Next-state, hold and RAM port control
  always_comb begin
    next_state_s = RIB_IDLE;
    hold_s       = 1'b0;
    accept_s     = 1'b0;
    ram_we_s     = 1'b0;
    ram_re_s     = 1'b0;
    ram_rzero_s  = 1'b0;
    ram_idx_s    = idx_r;
    case (state_r)
      RIB_IDLE: begin
        hold_s      = req_i;
        accept_s    = req_i;
        ram_idx_s   = addr_idx_s;
        ram_rzero_s = ~in_range_s;
        // Write commits on the accept edge; reset blocks a same-cycle write
        ram_we_s    = req_i & (we_i == WRITE_ENABLE) & in_range_s & ~rst;
        // Without wait states the read is captured on the accept edge itself
        ram_re_s    = req_i & (we_i != WRITE_ENABLE) & ~HAS_WAIT;
        if (req_i) begin
          next_state_s = HAS_WAIT ? RIB_WAIT : RIB_RESP;
        end else begin
          next_state_s = RIB_IDLE;
        end
      end
      RIB_WAIT: begin
        hold_s      = 1'b1;
        ram_idx_s   = idx_r;
        ram_rzero_s = ~in_range_r;
        if (cnt_r == 4'd0) begin
          next_state_s = RIB_RESP;
          ram_re_s     = (we_r != WRITE_ENABLE);
        end else begin
          next_state_s = RIB_WAIT;
          ram_re_s     = 1'b0;
        end
      end
      RIB_RESP: begin
        // req_i is ignored here: the core is consuming the response
        hold_s       = 1'b0;
        next_state_s = RIB_IDLE;
      end
      default: begin
        hold_s       = 1'b0;
        next_state_s = RIB_IDLE;
      end
    endcase
  end

  // FSM state, wait counter, latched transaction and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RIB_IDLE;
      cnt_r      <= 4'd0;
      we_r       <= 1'b0;
      idx_r      <= {IDX_W{1'b0}};
      in_range_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r <= next_state_s;
      err_r   <= err_r | (accept_s & ~in_range_s);
      case (state_r)
        RIB_IDLE: begin
          if (req_i) begin
            we_r       <= we_i;
            idx_r      <= addr_idx_s;
            in_range_r <= in_range_s;
            cnt_r      <= WAIT_INIT;
          end
        end
        RIB_WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  rib_ram_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we_s),
    .re    (ram_re_s),
    .rzero (ram_rzero_s),
    .idx   (ram_idx_s),
    .wdata (data_i),
    .rdata (ram_rdata_s)
  );

  assign data_o      = ram_rdata_s;
  assign hold_flag_o = hold_s;
  assign err_o       = err_r;

endmodule
